ram_dumper: RTL and testbench
=============================

# ram_dumper

UART readback engine for the cache-line BRAM; the transmit-side counterpart of the UART RAM programmer. On a start pulse it reads a range of 32-bit words through the BRAM's registered cache-line read port and serializes each word over a UART TX line (8N1, little-endian bytes). It sits beside the RAM programmer and drives the RAM read port only while the system is held in programming/debug mode; arbitration is external.

## Interface
- CACHE_LINE_WIDTH, 128: RAM line width in bits; multiple of 32.
- RAM_DEPTH, 32768: RAM size in 32-bit words; power of two.
- CLK_FREQ, ceres_param::CPU_CLK: clock frequency in Hz.
- BAUD_RATE, ceres_param::PROG_BAUD_RATE: UART bit rate; BAUD_DIV = CLK_FREQ / BAUD_RATE, integer division, must be ≥ 2.

- clk_i  in  1  single clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle request; sampled only in IDLE.
- start_addr_i  in  $clog2(RAM_DEPTH)  first word address.
- word_count_i  in  $clog2(RAM_DEPTH)+1  number of words to send.
- ram_addr_o  out  $clog2(RAM_DEPTH)  word address to RAM.
- ram_rd_en_o  out  1  read enable to RAM.
- ram_rdata_i  in  CACHE_LINE_WIDTH  registered RAM line data, valid the cycle after ram_rd_en_o.
- uart_tx_o  out  1  serial output, idle high.
- busy_o  out  1  high from the cycle after an accepted start until done_o.
- done_o  out  1  one-cycle pulse at completion.

## Operation
- FSM states: IDLE, READ, CAPTURE, SEND, NEXT, (TRAILER), DONE.
- IDLE: if start_i, latch start_addr_i and word_count_i. If count is 0, go to DONE; otherwise go to READ.
- READ: ram_rd_en_o = 1 for exactly one cycle with ram_addr_o = the current address. Go to CAPTURE.
- CAPTURE: select word index addr[$clog2(CACHE_LINE_WIDTH/32)-1:0] from ram_rdata_i (bits idx*32 +: 32) into a 32-bit shift register, byte counter = 0. Go to SEND.
- SEND: hand bytes to the serializer LSB byte first (bits 7:0, then 15:8, …). After the 4th byte's stop bit completes, go to NEXT.
- NEXT: address increments modulo RAM_DEPTH (0x7FFF → 0x0000); count decrements. If remaining count is 0, go to DONE (or TRAILER when configured); otherwise go to READ.
- DONE: done_o = 1 for one cycle, busy_o drops in the same cycle. Go to IDLE.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts BAUD_DIV cycles. Bytes within a word are sent back-to-back, with no idle bits between frames.
- start_i outside IDLE is ignored. ram_rd_en_o is 0 in every state except READ.
- rst_i at any time: the FSM returns to IDLE and uart_tx_o = 1 on the next edge. A partial frame is abandoned and no done_o is produced.

## Timing
- Reset values: uart_tx_o = 1, ram_rd_en_o = 0, ram_addr_o = 0, busy_o = 0, done_o = 0.
- Start accepted at edge N: busy_o = 1 from N+1; READ in cycle N+1; CAPTURE in N+2; start bit of the first byte drives uart_tx_o from N+3.
- Per word: 40·BAUD_DIV cycles of serial data plus 3 cycles of overhead (NEXT, READ, CAPTURE). With a zero count, done_o is asserted in cycle N+1.
- uart_tx_o comes from a flop with no combinational path from inputs.

## Configuration
- RAM_DUMPER_CHECKSUM_EN defined: after the last word, the TRAILER state sends one additional byte equal to the XOR of all transmitted data bytes, then goes to DONE. A zero-count dump sends a checksum of 0x00.
- Not defined: the TRAILER state, its logic and the checksum register are absent. NEXT goes directly to DONE.

## Structure
- The dumper state enum (dump_state_e) and the UART frame constants (UART_DATA_BITS = 8, UART_IDLE = 1'b1) go in ceres_param.
- Sub-module uart_tx_byte: 8N1 serializer with a valid/ready handshake, a baud counter and a bit counter. Its ready output is high only when it is idle. The dumper FSM drives valid during SEND.

## Test plan
All scenarios use CLK_FREQ = 8, BAUD_RATE = 1 (BAUD_DIV = 8), with a RAM model that has one cycle of read latency.
- Line 0 = {0x44444444, 0x33333333, 0x22222222, 0x11111111}; start_addr = 1, count = 1 → one ram_rd_en pulse at address 1, UART bytes 0x22 ×4, done_o after 320 serial cycles, busy_o = 0 afterwards.
- Word at address 5 = 0xDEADBEEF, count = 1 → bytes EF, BE, AD, DE; each start bit low for 8 cycles, stop bit high.
- start_addr = 0x7FFF, count = 2 → read addresses 0x7FFF then 0x0000.
- count = 0 → done_o in the cycle after start, uart_tx_o stays 1, ram_rd_en_o never asserted.
- start_i pulsed again mid-transfer → ignored; byte stream and total length unchanged.
- rst_i asserted mid-byte → uart_tx_o = 1 and busy_o = 0 on the next edge, no done_o. With RAM_DUMPER_CHECKSUM_EN, words 0x01020304 and 0x00000001 give a trailer byte of 0x05.

Source files
------------

// File: rtl/ceres_param.sv
// Shared system constants and state encodings for the programming/debug UART blocks.
// RAM_DUMPER_CHECKSUM_EN adds the TRAILER state to the dumper FSM.
package ceres_param;

    localparam int unsigned CPU_CLK        = 50_000_000;
    localparam int unsigned PROG_BAUD_RATE = 115_200;
    localparam int unsigned UART_DATA_BITS = 8;
    localparam logic        UART_IDLE      = 1'b1;

`ifdef RAM_DUMPER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_CAPTURE, S_SEND, S_NEXT, S_TRAILER, S_DONE
    } dump_state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_CAPTURE, S_SEND, S_NEXT, S_DONE
    } dump_state_e;
`endif

    typedef enum logic [1:0] {
        U_IDLE, U_START, U_DATA, U_STOP
    } uart_state_e;

endpackage

// File: rtl/ram_dumper_uart_tx_byte.sv
// 8N1 UART byte serializer with a valid/ready handshake; ready only while idle.
module uart_tx_byte
    import ceres_param::*;
#(
    parameter int unsigned BAUD_DIV = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    input  logic [UART_DATA_BITS-1:0] data_i,
    output logic                      ready_o,
    output logic                      tx_o
);

    localparam int unsigned CW = $clog2(BAUD_DIV);
    localparam int unsigned BW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(BAUD_DIV - 2);
    localparam logic [BW-1:0] DATA_LAST = BW'(UART_DATA_BITS - 1);

    uart_state_e               state;
    logic [CW-1:0]             baud_cnt;
    logic [BW-1:0]             bit_cnt;
    logic [UART_DATA_BITS-1:0] shreg;

    assign ready_o = (state == U_IDLE);

    // The stop phase counts BAUD_DIV-1 cycles; the idle cycle that follows is the
    // last stop-bit cycle, so a byte accepted there follows with no gap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= U_IDLE;
            tx_o     <= UART_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                U_IDLE: begin
                    if (valid_i) begin
                        shreg    <= data_i;
                        tx_o     <= 1'b0;
                        baud_cnt <= '0;
                        state    <= U_START;
                    end
                end
                U_START: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx_o     <= shreg[0];
                        shreg    <= shreg >> 1;
                        state    <= U_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                U_DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        if (bit_cnt == DATA_LAST) begin
                            tx_o  <= UART_IDLE;
                            state <= U_STOP;
                        end else begin
                            tx_o    <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                U_STOP: begin
                    if (baud_cnt == STOP_LAST) begin
                        baud_cnt <= '0;
                        state    <= U_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= U_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ram_dumper.sv
// UART readback engine: reads a word range from the cache-line BRAM and sends it 8N1, LSB byte first.
// Define RAM_DUMPER_CHECKSUM_EN to append an XOR checksum byte after the last word.
module ram_dumper
    import ceres_param::*;
#(
    parameter int unsigned CACHE_LINE_WIDTH = 128,
    parameter int unsigned RAM_DEPTH        = 32768,
    parameter int unsigned CLK_FREQ         = ceres_param::CPU_CLK,
    parameter int unsigned BAUD_RATE        = ceres_param::PROG_BAUD_RATE
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic [$clog2(RAM_DEPTH)-1:0]  start_addr_i,
    input  logic [$clog2(RAM_DEPTH):0]    word_count_i,
    output logic [$clog2(RAM_DEPTH)-1:0]  ram_addr_o,
    output logic                          ram_rd_en_o,
    input  logic [CACHE_LINE_WIDTH-1:0]   ram_rdata_i,
    output logic                          uart_tx_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int unsigned AW       = $clog2(RAM_DEPTH);
    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int unsigned WPL      = CACHE_LINE_WIDTH / 32;
    localparam int unsigned IDXW     = (WPL > 1) ? $clog2(WPL) : 1;
    localparam logic [2:0]  BYTES_PER_WORD = 3'd4;
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    dump_state_e                 state;
    logic [AW:0]                 count;
    logic [2:0]                  byte_cnt;
    logic [31:0]                 shreg;
    logic [31:0]                 sel_word;
    logic [IDXW-1:0]             word_idx;
    logic                        tx_valid;
    logic                        tx_ready;
    logic [UART_DATA_BITS-1:0]   tx_data;
`ifdef RAM_DUMPER_CHECKSUM_EN
    logic [UART_DATA_BITS-1:0]   csum;
    logic                        trailer_sent;
`endif

    assign word_idx = (WPL > 1) ? ram_addr_o[IDXW-1:0] : '0;

    always_comb begin
        sel_word = '0;
        for (int unsigned i = 0; i < WPL; i++) begin
            if (word_idx == IDXW'(i)) sel_word = ram_rdata_i[i*32 +: 32];
        end
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = shreg[7:0];
        case (state)
            S_CAPTURE: begin
                tx_valid = 1'b1;
                tx_data  = sel_word[7:0];
            end
            S_SEND:    tx_valid = (byte_cnt != BYTES_PER_WORD);
`ifdef RAM_DUMPER_CHECKSUM_EN
            S_TRAILER: begin
                tx_valid = !trailer_sent;
                tx_data  = csum;
            end
`endif
            default: ;
        endcase
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (tx_valid),
        .data_i  (tx_data),
        .ready_o (tx_ready),
        .tx_o    (uart_tx_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            ram_addr_o   <= '0;
            ram_rd_en_o  <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            count        <= '0;
            byte_cnt     <= '0;
            shreg        <= '0;
`ifdef RAM_DUMPER_CHECKSUM_EN
            csum         <= '0;
            trailer_sent <= 1'b0;
`endif
        end else begin
            ram_rd_en_o <= 1'b0;
            done_o      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        ram_addr_o <= start_addr_i;
                        count      <= word_count_i;
`ifdef RAM_DUMPER_CHECKSUM_EN
                        csum         <= '0;
                        trailer_sent <= 1'b0;
`endif
                        if (word_count_i == '0) begin
`ifdef RAM_DUMPER_CHECKSUM_EN
                            state  <= S_TRAILER;
                            busy_o <= 1'b1;
`else
                            state  <= S_DONE;
                            done_o <= 1'b1;
`endif
                        end else begin
                            state       <= S_READ;
                            ram_rd_en_o <= 1'b1;
                            busy_o      <= 1'b1;
                        end
                    end
                end
                S_READ: state <= S_CAPTURE;
                // Byte 0 is handed to the serializer straight from the RAM data in
                // this cycle, so the shift register keeps only the remaining bytes.
                S_CAPTURE: begin
                    shreg    <= {8'h00, sel_word[31:8]};
                    byte_cnt <= 3'd1;
                    state    <= S_SEND;
                end
                S_SEND: begin
                    if (byte_cnt != BYTES_PER_WORD) begin
                        if (tx_ready) begin
                            shreg    <= shreg >> 8;
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end else if (tx_ready) begin
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    ram_addr_o <= ram_addr_o + 1'b1;
                    count      <= count - 1'b1;
                    if (count == CNT_ONE) begin
`ifdef RAM_DUMPER_CHECKSUM_EN
                        state  <= S_TRAILER;
`else
                        state  <= S_DONE;
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
`endif
                    end else begin
                        state       <= S_READ;
                        ram_rd_en_o <= 1'b1;
                    end
                end
`ifdef RAM_DUMPER_CHECKSUM_EN
                S_TRAILER: begin
                    if (!trailer_sent) begin
                        if (tx_ready) trailer_sent <= 1'b1;
                    end else if (tx_ready) begin
                        state  <= S_DONE;
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                    end
                end
`endif
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
`ifdef RAM_DUMPER_CHECKSUM_EN
            if (tx_valid && tx_ready && state != S_TRAILER) csum <= csum ^ tx_data;
`endif
        end
    end

endmodule

// File: tb/tb_ram_dumper.sv
// Self-checking bench for ram_dumper: table of directed dumps, random dumps, and a mid-byte reset.
module tb_ram_dumper;

    localparam int unsigned B  = 8;
    localparam int unsigned AW = 15;
`ifdef RAM_DUMPER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [AW-1:0] start_addr_i = '0;
    logic [AW:0]   word_count_i = '0;
    logic [AW-1:0] ram_addr_o;
    logic          ram_rd_en_o;
    logic [127:0]  ram_rdata = '0;
    logic          uart_tx_o;
    logic          busy_o;
    logic          done_o;

    logic [31:0] mem [0:32767];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_dumper #(
        .CACHE_LINE_WIDTH (128),
        .RAM_DEPTH        (32768),
        .CLK_FREQ         (8),
        .BAUD_RATE        (1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .start_addr_i (start_addr_i),
        .word_count_i (word_count_i),
        .ram_addr_o   (ram_addr_o),
        .ram_rd_en_o  (ram_rd_en_o),
        .ram_rdata_i  (ram_rdata),
        .uart_tx_o    (uart_tx_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    // Registered cache-line RAM, one cycle of read latency.
    always @(posedge clk) begin
        if (ram_rd_en_o)
            ram_rdata <= {mem[{ram_addr_o[14:2], 2'd3}], mem[{ram_addr_o[14:2], 2'd2}],
                          mem[{ram_addr_o[14:2], 2'd1}], mem[{ram_addr_o[14:2], 2'd0}]};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] sa;
        logic [AW:0]   cnt;
        bit            restart;
        int            exp_first;
        int            exp_rd;
    } vec_t;

    task automatic run_dump(input string nm, input logic [AW-1:0] sa, input logic [AW:0] cnt,
                            input bit restart, input int exp_first, input int exp_rd);
        logic [7:0]    expb[$];
        int            exps[$];
        logic [AW-1:0] expa[$];
        logic [7:0]    gotb[$];
        int            gots[$];
        logic [AW-1:0] rda[$];
        bit            q[$];
        logic [7:0]    ck;
        logic [31:0]   w;
        int            t, done_exp, done_cyc, limit, ones, i, n;
        logic          busy1, busy_done;
        bit            ferr;
        ck = '0; done_cyc = 0; busy1 = 1'b0; busy_done = 1'b1; ferr = 1'b0; ones = 0;

        // Expected stream from the serial timing rules: word period 40*B+3, first start bit at cycle 3.
        for (int wi = 0; wi < int'(cnt); wi++) begin
            logic [AW-1:0] a;
            a = sa + AW'(wi);
            expa.push_back(a);
            w = mem[a];
            for (int k = 0; k < 4; k++) begin
                logic [7:0] bv;
                bv = w[8*k +: 8];
                expb.push_back(bv);
                ck ^= bv;
                exps.push_back(3 + wi*(40*B+3) + k*10*B);
            end
        end
        if (cnt == 0) t = 1;
        else t = 4 + 40*B*int'(cnt) + 3*(int'(cnt) - 1);
        if (CK) begin
            expb.push_back(ck);
            exps.push_back(t + 1);
            done_exp = t + 10*B + 1;
        end else begin
            done_exp = t;
        end
        limit = done_exp + 40;

        @(negedge clk);
        start_addr_i = sa;
        word_count_i = cnt;
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        for (int cyc = 1; cyc <= limit; cyc++) begin
            @(negedge clk);
            if (restart) begin
                if (cyc == 100) begin
                    start_i = 1'b1;
                    start_addr_i = '0;
                    word_count_i = 7;
                end else begin
                    start_i = 1'b0;
                end
            end
            q.push_back(uart_tx_o);
            if (uart_tx_o === 1'b1) ones++;
            if (ram_rd_en_o) rda.push_back(ram_addr_o);
            if (cyc == 1) busy1 = busy_o;
            if (done_o) begin
                done_cyc = cyc;
                busy_done = busy_o;
                break;
            end
        end
        start_i = 1'b0;

        chk({nm, " done cycle"}, done_cyc, done_exp);
        chk({nm, " busy after start"}, busy1, (cnt != 0 || CK) ? 1'b1 : 1'b0);
        chk({nm, " busy at done"}, busy_done, 1'b0);

        i = 0;
        while (i < q.size()) begin
            if (q[i] == 1'b0) begin
                logic [7:0] bv;
                bv = '0;
                gots.push_back(i + 1);
                for (int j = 0; j < 10*B; j++) begin
                    bit ev;
                    if (i + j >= q.size()) begin
                        ferr = 1'b1;
                        break;
                    end
                    if (j < B) ev = 1'b0;
                    else if (j >= 9*B) ev = 1'b1;
                    else ev = q[i + (j/B)*B];
                    if (q[i + j] != ev) ferr = 1'b1;
                end
                for (int b2 = 0; b2 < 8; b2++)
                    if (i + (b2+1)*B < q.size()) bv[b2] = q[i + (b2+1)*B];
                gotb.push_back(bv);
                i += 10*B;
            end else begin
                i++;
            end
        end

        chk({nm, " frame format"}, ferr, 1'b0);
        chk({nm, " byte count"}, gotb.size(), expb.size());
        n = (gotb.size() < expb.size()) ? gotb.size() : expb.size();
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s byte%0d", nm, k), gotb[k], expb[k]);
            chk($sformatf("%s start%0d", nm, k), gots[k], exps[k]);
        end
        if (exp_first >= 0 && gotb.size() > 0) chk({nm, " first byte"}, gotb[0], exp_first);
        chk({nm, " read pulses"}, rda.size(), exp_rd);
        n = (rda.size() < expa.size()) ? rda.size() : expa.size();
        for (int k = 0; k < n; k++) chk($sformatf("%s rd addr%0d", nm, k), rda[k], expa[k]);
        if (cnt == 0 && !CK) chk({nm, " tx idle"}, ones, q.size());

        @(negedge clk);
        chk({nm, " done after"}, done_o, 1'b0);
        chk({nm, " busy after"}, busy_o, 1'b0);
        chk({nm, " tx idle after"}, uart_tx_o, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   dones, lows;

        for (int a = 0; a < 32768; a++) mem[a] = $urandom;
        mem[0] = 32'h11111111; mem[1] = 32'h22222222;
        mem[2] = 32'h33333333; mem[3] = 32'h44444444;
        mem[5] = 32'hDEADBEEF;
        mem[15'h7FFF] = 32'hCAFEF00D;
        mem[100] = 32'h01020304; mem[101] = 32'h00000001;

        vecs[0] = '{sa: 15'd1,      cnt: 16'd1, restart: 1'b0, exp_first: 'h22, exp_rd: 1};
        vecs[1] = '{sa: 15'd5,      cnt: 16'd1, restart: 1'b0, exp_first: 'hEF, exp_rd: 1};
        vecs[2] = '{sa: 15'h7FFF,   cnt: 16'd2, restart: 1'b0, exp_first: 'h0D, exp_rd: 2};
        vecs[3] = '{sa: 15'd9,      cnt: 16'd0, restart: 1'b0, exp_first: -1,   exp_rd: 0};
        vecs[4] = '{sa: 15'd5,      cnt: 16'd2, restart: 1'b1, exp_first: 'hEF, exp_rd: 2};
        vecs[5] = '{sa: 15'd100,    cnt: 16'd2, restart: 1'b0, exp_first: 'h04, exp_rd: 2};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset tx", uart_tx_o, 1'b1);
        chk("reset rd_en", ram_rd_en_o, 1'b0);
        chk("reset addr", ram_addr_o, 0);
        chk("reset busy", busy_o, 1'b0);
        chk("reset done", done_o, 1'b0);
        rst_i = 1'b0;

        for (int v = 0; v < 6; v++)
            run_dump($sformatf("vec%0d", v), vecs[v].sa, vecs[v].cnt, vecs[v].restart,
                     vecs[v].exp_first, vecs[v].exp_rd);

        if (CK) begin
            logic [7:0] trailer;
            trailer = mem[100][7:0] ^ mem[100][15:8] ^ mem[100][23:16] ^ mem[100][31:24]
                    ^ mem[101][7:0] ^ mem[101][15:8] ^ mem[101][23:16] ^ mem[101][31:24];
            chk("trailer model", trailer, 8'h05);
        end

        // Reset in the middle of a byte: 0xEF bit 4 is low in cycles 43..50.
        @(negedge clk);
        start_addr_i = 5;
        word_count_i = 1;
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (45) @(negedge clk);
        chk("mid-byte tx", uart_tx_o, 1'b0);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        chk("rst tx", uart_tx_o, 1'b1);
        chk("rst busy", busy_o, 1'b0);
        @(negedge clk);
        rst_i = 1'b0;
        dones = 0;
        lows = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (done_o) dones++;
            if (uart_tx_o !== 1'b1) lows++;
        end
        chk("rst no done", dones, 0);
        chk("rst tx idle", lows, 0);

        for (int r = 0; r < 6; r++) begin
            logic [AW-1:0] sa;
            logic [AW:0]   cnt;
            sa = AW'($urandom);
            cnt = (AW+1)'($urandom_range(1, 3));
            run_dump($sformatf("rand%0d", r), sa, cnt, 1'b0, -1, int'(cnt));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
